// File: rtl/rle_pkg.sv
// Shared types and defaults for the run-length packer.
// Used by rle_packer, rle_out_reg and rle_packer_if.
package rle_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 8;
    localparam int CNT_MAX   = (1 << CNT_W_DEF) - 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } rle_state_e;

endpackage

// File: rtl/rle_packer_if.sv
// Symbol input stream plus run output stream of rle_packer.
// master = traffic source/sink side, slave = packer side.
interface rle_packer_if
    import rle_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid,
        output data_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_value,
        input  out_count
    );

    modport slave (
        input  in_valid,
        input  data_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_value,
        output out_count
    );

endinterface

// File: rtl/rle_out_reg.sv
// Holding register for one completed run (value, count).
// A load in the same cycle as a transfer replaces it without a bubble.
module rle_out_reg
    import rle_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_p,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [CNT_W-1:0] load_count,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_value,
    output logic [CNT_W-1:0] out_count
);

    // Capture a new run, or drop valid once the current one is taken.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_value <= '0;
            out_count <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_value <= load_value;
            out_count <= load_count;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rle_packer.sv
// Run-length packer: collapses equal consecutive symbols into (value, count).
// Optional flush input compiled in with RLE_FLUSH_EN.
module rle_packer
    import rle_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic        clk_p,
    input  logic        rst_n,
`ifdef RLE_FLUSH_EN
    input  logic        flush,
`endif
    rle_packer_if.slave bus
);

    localparam logic [CNT_W-1:0] RUN_MAX = '1;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    rle_state_e       state;
    logic [WIDTH-1:0] run_val;
    logic [CNT_W-1:0] run_cnt;

    logic out_busy;
    logic flush_req;
    logic accept;
    logic run_break;
    logic beat_emit;
    logic flush_emit;
    logic emit;

`ifdef RLE_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    assign out_busy   = bus.out_valid && !bus.out_ready;
    assign bus.in_ready = !out_busy && !flush_req;
    assign accept     = bus.in_valid && bus.in_ready;
    assign run_break  = (bus.data_in != run_val) || (run_cnt == RUN_MAX);
    assign beat_emit  = accept && (state == RUN) && run_break;
    assign flush_emit = flush_req && (state == RUN) && !out_busy;
    assign emit       = beat_emit || flush_emit;

    // Run tracker: start, extend or restart the pending run.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            run_val <= '0;
            run_cnt <= '0;
        end else if (flush_emit) begin
            state   <= IDLE;
            run_cnt <= '0;
        end else if (accept) begin
            unique case (state)
                IDLE: begin
                    state   <= RUN;
                    run_val <= bus.data_in;
                    run_cnt <= ONE;
                end
                RUN: begin
                    if (run_break) begin
                        run_val <= bus.data_in;
                        run_cnt <= ONE;
                    end else begin
                        run_cnt <= run_cnt + ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    rle_out_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_out_reg (
        .clk_p      (clk_p),
        .rst_n      (rst_n),
        .load       (emit),
        .load_value (run_val),
        .load_count (run_cnt),
        .out_ready  (bus.out_ready),
        .out_valid  (bus.out_valid),
        .out_value  (bus.out_value),
        .out_count  (bus.out_count)
    );

endmodule

// File: tb/tb_rle_packer.sv
// Scoreboard bench for rle_packer.
// Flush scenario compiled in with RLE_FLUSH_EN.
module tb_rle_packer;
    import rle_pkg::*;

    logic clk_p = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk_p = ~clk_p;

`ifdef RLE_FLUSH_EN
    logic flush = 1'b0;
`endif

    rle_packer_if #(.WIDTH(8), .CNT_W(8)) bus ();

    rle_packer #(.WIDTH(8), .CNT_W(8)) dut (
        .clk_p (clk_p),
        .rst_n (rst_n),
`ifdef RLE_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int m_sum   = 0;
    int d_sum   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] mon_e;
    bit          m_run = 1'b0;
    logic [7:0]  m_val = '0;
    int          m_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_run(input logic [7:0] v, input int c);
        exp_q.push_back({v, 8'(c)});
        m_sum += c;
    endtask

    task automatic model_beat(input logic [7:0] v);
        if (!m_run) begin
            m_run = 1'b1;
            m_val = v;
            m_cnt = 1;
        end else if (v != m_val || m_cnt == CNT_MAX) begin
            push_run(m_val, m_cnt);
            m_val = v;
            m_cnt = 1;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_run = 1'b0;
        m_val = '0;
        m_cnt = 0;
        m_sum = 0;
        d_sum = 0;
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [7:0] v);
        int   tries;
        logic rdy;
        tries = 0;
        bus.in_valid = 1'b1;
        bus.data_in  = v;
        forever begin
            #2;
            rdy = bus.in_ready;
            @(posedge clk_p);
            if (rdy) begin
                model_beat(v);
                break;
            end
            tries++;
            if (tries > 50) begin
                check("send_timeout", 1, 0);
                break;
            end
            @(negedge clk_p);
        end
        @(negedge clk_p);
        bus.in_valid = 1'b0;
    endtask

    always @(posedge clk_p) cyc++;

    // Output monitor: samples mid low phase, just before the edge.
    always begin
        @(negedge clk_p);
        #3;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_value", 32'(bus.out_value), 32'(mon_e[15:8]));
                check("out_count", 32'(bus.out_count), 32'(mon_e[7:0]));
            end
            d_sum += int'(bus.out_count);
        end
    end

    initial begin
        int c0;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b1;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_value", 32'(bus.out_value), 0);
        check("rst_out_count", 32'(bus.out_count), 0);
        repeat (2) @(negedge clk_p);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 1);
        @(negedge clk_p);

        // 5,5,5,7 -> (5,3) on the edge taking 7
        send(8'd5); send(8'd5); send(8'd5);
        check("t1_no_emit", 32'(bus.out_valid), 0);
        send(8'd7);
        check("t1_valid", 32'(bus.out_valid), 1);
        check("t1_value", 32'(bus.out_value), 5);
        check("t1_count", 32'(bus.out_count), 3);

        // 300 x 0xAA: saturate at 255, then a run of 45
        for (int i = 0; i < 300; i++) begin
            send(8'hAA);
            if (i == 255) begin
                check("sat_valid", 32'(bus.out_valid), 1);
                check("sat_value", 32'(bus.out_value), 32'hAA);
                check("sat_count", 32'(bus.out_count), 255);
            end
        end
        send(8'h55);
        check("tail_count", 32'(bus.out_count), 45);

        // backpressure while (3,2) is held
        send(8'd3); send(8'd3);
        bus.out_ready = 1'b0;
        send(8'd4);
        bus.in_valid = 1'b1;
        bus.data_in  = 8'd5;
        for (int i = 0; i < 4; i++) begin
            #2;
            check("bp_valid", 32'(bus.out_valid), 1);
            check("bp_value", 32'(bus.out_value), 3);
            check("bp_count", 32'(bus.out_count), 2);
            check("bp_in_ready", 32'(bus.in_ready), 0);
            @(negedge clk_p);
        end
        bus.out_ready = 1'b1;
        send(8'd5);

        // alternating symbols, one pair per cycle
        c0 = cyc;
        send(8'd1);
        send(8'd2);
        check("alt_v1", 32'(bus.out_value), 1);
        send(8'd1);
        check("alt_v2", 32'(bus.out_value), 2);
        check("alt_valid", 32'(bus.out_valid), 1);
        send(8'd2);
        check("alt_v3", 32'(bus.out_value), 1);
        check("alt_cycles", 32'(cyc - c0), 4);

        // reset mid-run of 9s
        for (int i = 0; i < 4; i++) send(8'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 0);
        check("mid_rst_count", 32'(bus.out_count), 0);
        model_reset();
        @(negedge clk_p);
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        send(8'd9);
        send(8'd8);
        check("fresh_count", 32'(bus.out_count), 1);
        check("fresh_value", 32'(bus.out_value), 9);

        // reset with an un-consumed output
        #2;
        rst_n = 1'b0;
        #1;
        check("held_rst_valid", 32'(bus.out_valid), 0);
        check("held_rst_value", 32'(bus.out_value), 0);
        check("held_rst_count", 32'(bus.out_count), 0);
        check("held_rst_ready", 32'(bus.in_ready), 1);
        model_reset();
        @(negedge clk_p);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send(8'd9);
        send(8'd1);

`ifdef RLE_FLUSH_EN
        send(8'd4); send(8'd4);
        flush = 1'b1;
        #2;
        check("fl_in_ready", 32'(bus.in_ready), 0);
        @(posedge clk_p);
        push_run(m_val, m_cnt);
        m_run = 1'b0;
        @(negedge clk_p);
        check("fl_valid", 32'(bus.out_valid), 1);
        check("fl_value", 32'(bus.out_value), 4);
        check("fl_count", 32'(bus.out_count), 2);
        flush = 1'b0;
        send(8'd6);
        check("fl_idle", 32'(bus.out_valid), 0);
        send(8'd7);
`endif

        send(8'h11);
        repeat (3) @(negedge clk_p);
        check("q_empty", 32'(exp_q.size()), 0);
        check("beat_sum", 32'(d_sum), 32'(m_sum));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
